// File: rtl/csr_pkg.sv
// CSR package: access op encodings, access-unit FSM states, CSR address map.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package csr_pkg;

  typedef logic [11:0] csr_addr_t;

  // Existing CSR address constants
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MISA      = 12'h301;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MVENDORID = 12'hF11;
  localparam csr_addr_t CSR_MARCHID   = 12'hF12;
  localparam csr_addr_t CSR_MIMPID    = 12'hF13;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;

  // Addresses that exist in this core's CSR file
  localparam int CSR_NUM_SUPPORTED = 15;
  localparam csr_addr_t CSR_SUPPORTED [CSR_NUM_SUPPORTED] = '{
    CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
    CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE,
    CSR_MINSTRET, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID
  };

  // funct3 encodings; 000 and 100 are not CSR ops but are named so the
  // enum covers every 3-bit value and casts from the raw field are total.
  typedef enum logic [2:0] {
    CSR_OP_RSV0 = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RSV4 = 3'b100,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    CSR_ST_IDLE  = 2'd0,
    CSR_ST_READ  = 2'd1,
    CSR_ST_WRITE = 2'd2,
    CSR_ST_RESP  = 2'd3
  } csr_state_t;

  // Immediate forms take zimm as the operand instead of rs1
  function automatic logic csr_op_is_imm(input csr_op_t op);
    return op[2];
  endfunction

  // Ops 000/100 carry no CSR semantics
  function automatic logic csr_op_valid(input csr_op_t op);
    return (op != CSR_OP_RSV0) && (op != CSR_OP_RSV4);
  endfunction

  // Set/clear with a zero source is a pure read and must not write
  function automatic logic csr_write_required(input csr_op_t op, input logic src_zero);
    logic req;
    case (op)
      CSR_OP_RW, CSR_OP_RWI:                       req = 1'b1;
      CSR_OP_RS, CSR_OP_RC, CSR_OP_RSI, CSR_OP_RCI: req = !src_zero;
      default:                                     req = 1'b0;
    endcase
    return req;
  endfunction

  // Top two address bits 11 mark the read-only CSR space
  function automatic logic csr_read_only(input csr_addr_t addr);
    return addr[11:10] == 2'b11;
  endfunction

  function automatic logic csr_supported(input csr_addr_t addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < CSR_NUM_SUPPORTED; i++) begin
      if (CSR_SUPPORTED[i] == addr) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/csr_wdata_gen.sv
// CSR write-value generator: new value from op, old CSR value and operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module csr_wdata_gen
  import csr_pkg::*;
(
  input  csr_op_t     op,
  input  logic [63:0] old_val,
  input  logic [63:0] src,
  output logic [63:0] wdata
);

  // Write / set / clear; non-ops leave the old value unchanged
  always_comb begin
    wdata = old_val;
    case (op)
      CSR_OP_RW, CSR_OP_RWI: wdata = src;
      CSR_OP_RS, CSR_OP_RSI: wdata = old_val | src;
      CSR_OP_RC, CSR_OP_RCI: wdata = old_val & ~src;
      default:               wdata = old_val;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: executes RISC-V CSR read-modify-write ops; optional illegal check via CSR_UNIT_ILLEGAL_CHECK_EN.
// Latency: accept to resp_valid 3 cycles with a CSR write, 2 without.
// Backpressure: one op in flight; req_ready only in IDLE, response held until resp_ready.
module csr_access_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [63:0] req_src,
  input  logic [4:0]  req_zimm,
  input  logic        req_src_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_illegal,
  output logic [11:0] csr_addr,
  output logic [63:0] csr_wdata,
  output logic        csr_we,
  input  logic [63:0] csr_rdata,
  output logic        mcycle_inc
);

  csr_state_t  state_q, state_d;
  csr_op_t     op_q, op_d;
  csr_addr_t   addr_q, addr_d;
  logic [63:0] src_q, src_d;
  logic [63:0] old_q, old_d;
  logic        we_req_q, we_req_d;
  logic        illegal_q, illegal_d;

  csr_op_t     in_op;
  logic [63:0] in_operand;
  logic        in_we_req;
  logic        in_illegal;
  logic [63:0] wdata_calc;

  // Decode the offered request so everything needed later is latched at accept
  always_comb begin
    in_op      = csr_op_t'(req_op);
    in_operand = csr_op_is_imm(in_op) ? {59'd0, req_zimm} : req_src;
    in_we_req  = csr_write_required(in_op, req_src_zero);
`ifdef CSR_UNIT_ILLEGAL_CHECK_EN
    in_illegal = !csr_supported(req_addr) || !csr_op_valid(in_op) ||
                 (in_we_req && csr_read_only(req_addr));
`else
    in_illegal = 1'b0;
`endif
  end

  csr_wdata_gen u_wdata_gen (
    .op      (op_q),
    .old_val (old_q),
    .src     (src_q),
    .wdata   (wdata_calc)
  );

  // Next-state and Moore outputs; the register-file port is idle (zero) in IDLE
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    src_d        = src_q;
    old_d        = old_q;
    we_req_d     = we_req_q;
    illegal_d    = illegal_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = 64'd0;
    resp_illegal = 1'b0;
    csr_addr     = 12'd0;
    csr_wdata    = 64'd0;
    csr_we       = 1'b0;
    case (state_q)
      CSR_ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d      = in_op;
          addr_d    = req_addr;
          src_d     = in_operand;
          we_req_d  = in_we_req;
          illegal_d = in_illegal;
          state_d   = CSR_ST_READ;
        end
      end
      CSR_ST_READ: begin
        csr_addr = addr_q;
        // Captured here so the response carries the pre-write value
        old_d    = csr_rdata;
        state_d  = (we_req_q && !illegal_q) ? CSR_ST_WRITE : CSR_ST_RESP;
      end
      CSR_ST_WRITE: begin
        csr_addr  = addr_q;
        csr_we    = 1'b1;
        csr_wdata = wdata_calc;
        state_d   = CSR_ST_RESP;
      end
      CSR_ST_RESP: begin
        csr_addr     = addr_q;
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        resp_rdata   = illegal_q ? 64'd0 : old_q;
        if (resp_ready) state_d = CSR_ST_IDLE;
      end
      default: state_d = CSR_ST_IDLE;
    endcase
  end

  // Cycle counter ticks whenever out of reset, except when software overwrites it
  always_comb begin
    mcycle_inc = reset && !((state_q == CSR_ST_WRITE) && (addr_q == CSR_MCYCLE));
  end

  // State and transaction registers; reset drops any in-flight op
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CSR_ST_IDLE;
      op_q      <= CSR_OP_RSV0;
      addr_q    <= 12'd0;
      src_q     <= 64'd0;
      old_q     <= 64'd0;
      we_req_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      old_q     <= old_d;
      we_req_q  <= we_req_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a CSR-file stub and a response scoreboard.
// Latency: checks accept-to-response cycle counts per transaction.
// Backpressure: exercises held resp_ready and reset mid-write.
module tb_csr_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [63:0] req_src;
  logic [4:0]  req_zimm;
  logic        req_src_zero;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        csr_we;
  logic [63:0] csr_rdata;
  logic        mcycle_inc;

  csr_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_zimm     (req_zimm),
    .req_src_zero (req_src_zero),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_we       (csr_we),
    .csr_rdata    (csr_rdata),
    .mcycle_inc   (mcycle_inc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CSR register-file stub: combinational read, write on rising edge
  logic [63:0] csr_mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_addr;
  logic [63:0] pre_data;
  assign csr_rdata = csr_mem[csr_addr];

  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_data;
    else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
  end

  // Bus monitor: write pulses and mcycle_inc low cycles
  int          we_cnt;
  int          mz_cnt;
  logic [11:0] last_waddr;
  logic [63:0] last_wdata;
  initial begin
    we_cnt = 0;
    mz_cnt = 0;
    last_waddr = '0;
    last_wdata = '0;
  end
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (csr_we === 1'b1) begin
        we_cnt     <= we_cnt + 1;
        last_waddr <= csr_addr;
        last_wdata <= csr_wdata;
      end
      if (mcycle_inc !== 1'b1) mz_cnt <= mz_cnt + 1;
    end
  end

  typedef struct packed {
    logic [63:0] rdata;
    logic        illegal;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb [$];

  int checks;
  int passed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks = checks + 1;
    assert (obs === exp_v) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic [2:0] op, input logic [11:0] addr,
                        input logic [63:0] src, input logic [4:0] zimm, input logic zf,
                        input logic [63:0] e_rdata, input logic e_ill, input int e_lat,
                        input int e_we, input logic [63:0] e_wdata, input int e_mz,
                        input int hold);
    exp_t e;
    int   lat;
    int   we0;
    int   mz0;
    e.rdata   = e_rdata;
    e.illegal = e_ill;
    e.lat     = 8'(e_lat);
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    we0 = we_cnt;
    mz0 = mz_cnt;
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_src = src; req_zimm = zimm; req_src_zero = zf;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_illegal"}, 64'(resp_illegal), 64'(e.illegal));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_done_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_we_pulses"}, 64'(we_cnt - we0), 64'(e_we));
    if (e_we != 0) begin
      chk({tag, "_waddr"}, 64'(last_waddr), 64'(addr));
      chk({tag, "_wdata"}, last_wdata, e_wdata);
    end
    chk({tag, "_mcycle_low"}, 64'(mz_cnt - mz0), 64'(e_mz));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    passed = 0;
    reset = 1'b0;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
    req_zimm = '0; req_src_zero = 1'b0; resp_ready = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_illegal", 64'(resp_illegal), 64'd0);
    chk("rst_csr_we", 64'(csr_we), 64'd0);
    chk("rst_csr_addr", 64'(csr_addr), 64'd0);
    chk("rst_csr_wdata", csr_wdata, 64'd0);
    chk("rst_mcycle_inc", 64'(mcycle_inc), 64'd0);
    reset = 1'b1;

    preload(12'h340, 64'h0);
    preload(12'h300, 64'h8);
    preload(12'hB00, 64'h55);
    preload(12'hF14, 64'h7);
    @(negedge clk);
    chk("run_mcycle_inc", 64'(mcycle_inc), 64'd1);

    //      tag      op     addr     src              zimm   zf    rdata          ill  lat we wdata            mz hold
    do_req("rw340",  3'b001, 12'h340, 64'hDEADBEEF,    5'h00, 1'b0, 64'h0,         1'b0, 3, 1, 64'hDEADBEEF,    0, 0);
    do_req("rs300z", 3'b010, 12'h300, 64'h1,           5'h00, 1'b1, 64'h8,         1'b0, 2, 0, 64'h0,           0, 0);
    preload(12'h340, 64'hFF);
    do_req("rci340", 3'b111, 12'h340, 64'h1234,        5'h0F, 1'b0, 64'hFF,        1'b0, 3, 1, 64'hF0,          0, 4);
    do_req("rwB00",  3'b001, 12'hB00, 64'h100,         5'h00, 1'b0, 64'h55,        1'b0, 3, 1, 64'h100,         1, 0);
    do_req("rs340",  3'b010, 12'h340, 64'hF00,         5'h00, 1'b0, 64'hF0,        1'b0, 3, 1, 64'hFF0,         0, 0);
    do_req("rc340",  3'b011, 12'h340, 64'hF0,          5'h00, 1'b0, 64'hFF0,       1'b0, 3, 1, 64'hF00,         0, 1);
    do_req("rwi340", 3'b101, 12'h340, 64'hFFFF_FFFF,   5'h1F, 1'b0, 64'hF00,       1'b0, 3, 1, 64'h1F,          0, 0);
    do_req("rsi0",   3'b110, 12'h340, 64'hFFFF,        5'h00, 1'b1, 64'h1F,        1'b0, 2, 0, 64'h0,           0, 0);
`ifdef CSR_UNIT_ILLEGAL_CHECK_EN
    do_req("rwF14",  3'b001, 12'hF14, 64'h123,         5'h00, 1'b0, 64'h0,         1'b1, 2, 0, 64'h0,           0, 0);
    do_req("op000",  3'b000, 12'h340, 64'h5,           5'h00, 1'b0, 64'h0,         1'b1, 2, 0, 64'h0,           0, 0);
`else
    do_req("rwF14",  3'b001, 12'hF14, 64'h123,         5'h00, 1'b0, 64'h7,         1'b0, 3, 1, 64'h123,         0, 0);
    do_req("op000",  3'b000, 12'h340, 64'h5,           5'h00, 1'b0, 64'h1F,        1'b0, 2, 0, 64'h0,           0, 0);
`endif

    // Reset asserted while the WRITE cycle is on the bus
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b001; req_addr = 12'h340;
    req_src = 64'hABC; req_zimm = '0; req_src_zero = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_we_before_reset", 64'(csr_we), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_csr_we", 64'(csr_we), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_csr_addr", 64'(csr_addr), 64'd0);
    chk("mid_rst_mcycle_inc", 64'(mcycle_inc), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    chk("post_rst_csr_we", 64'(csr_we), 64'd0);
    chk("post_rst_no_write", csr_mem[12'h340], 64'h1F);
    do_req("post_rs", 3'b010, 12'h340, 64'h0,          5'h00, 1'b1, 64'h1F,        1'b0, 2, 0, 64'h0,           0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
